fpu_cmd_sequencer: RTL and testbench

//  Initiator side of the FPU operation interface: accepts tagged FP commands on a

---
 rtl/fpu_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: queues tagged FP commands, drives the FPU start/done handshake
// one operation at a time and returns results in order, with timeout recovery.
module fpu_cmd_sequencer #(
    parameter int PRECISION    = 32,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64,
    parameter int TAG_W        = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [PRECISION-1:0]       cmd_a,
    input  logic [PRECISION-1:0]       cmd_b,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [PRECISION-1:0]       fpu_a,
    output logic [PRECISION-1:0]       fpu_b,
    output logic [1:0]                 fpu_op,
    output logic                       fpu_start,
    input  logic [PRECISION-1:0]       fpu_result,
    input  logic                       fpu_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [PRECISION-1:0]       rsp_result,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_timeout,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the
    // source keeps valid and its payload stable until that edge.
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EXP_W   = (PRECISION == 64) ? 11 : (PRECISION == 16) ? 5 : 8;
    localparam int ENTRY_W = 2 + TAG_W + 2 * PRECISION;
    localparam logic [PRECISION-1:0] QNAN =
        {1'b0, {(EXP_W + 1){1'b1}}, {(PRECISION - EXP_W - 2){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];
    logic [ENTRY_W-1:0]     head;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PRECISION-1:0]   fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]             fpu_op_q, fpu_op_d;
    logic                   fpu_start_q, fpu_start_d;
    logic [TAG_W-1:0]       iss_tag_q, iss_tag_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [PRECISION-1:0]   rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]       rsp_tag_q, rsp_tag_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   push, pop;

    // Reset gates cmd_ready directly so it drops the moment Reset goes low.
    assign cmd_ready = Reset && (occ_q < OCC_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_tag, cmd_a, cmd_b};
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        fpu_a_d       = fpu_a_q;
        fpu_b_d       = fpu_b_q;
        fpu_op_d      = fpu_op_q;
        fpu_start_d   = fpu_start_q;
        iss_tag_d     = iss_tag_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;
        pop           = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (occ_q != '0) begin
                    pop = 1'b1;
                    {fpu_op_d, iss_tag_d, fpu_a_d, fpu_b_d} = head;
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    fpu_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    fpu_start_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Done observed on the expiry cycle still counts as a normal finish.
                if (fpu_done) begin
                    rsp_result_d  = fpu_result;
                    rsp_timeout_d = 1'b0;
                    rsp_tag_d     = iss_tag_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_result_d  = QNAN;
                    rsp_timeout_d = 1'b1;
                    rsp_tag_d     = iss_tag_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    fpu_a_d     = '0;
                    fpu_b_d     = '0;
                    fpu_op_d    = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            cnt_q         <= '0;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_op_q      <= '0;
            fpu_start_q   <= 1'b0;
            iss_tag_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            cnt_q         <= cnt_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            fpu_op_q      <= fpu_op_d;
            fpu_start_q   <= fpu_start_d;
            iss_tag_q     <= iss_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_op      = fpu_op_q;
    assign fpu_start   = fpu_start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_timeout = rsp_timeout_q;
    assign occupancy   = occ_q;
    assign busy        = (state_q != S_IDLE) || (occ_q != '0);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: table vectors, hand-written corner sequences and a
// randomized run against a queue-based reference with a behavioural FPU model.
module tb_fpu_cmd_sequencer;

    localparam int PRECISION    = 32;
    localparam int DEPTH        = 4;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 64;
    localparam int TAG_W        = 4;
    localparam int OCC_W        = $clog2(DEPTH + 1);
    localparam int SB_W         = TAG_W + 1 + PRECISION;
    localparam int ISS_W        = 2 + 2 * PRECISION;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [3:0]       cmd_tag = '0;
    logic [31:0]      fpu_a, fpu_b, fpu_result;
    logic [1:0]       fpu_op;
    logic             fpu_start, fpu_done;
    logic             rsp_valid, rsp_timeout;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_tag;
    logic [OCC_W-1:0] occupancy;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en = 1'b0;
    bit rand_ready = 1'b0;

    logic [SB_W-1:0]  exp_q [$];
    logic [ISS_W-1:0] iss_q [$];

    always #5 clk = ~clk;

    fpu_cmd_sequencer #(
        .PRECISION(PRECISION), .DEPTH(DEPTH), .START_CYCLES(START_CYCLES),
        .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)
    ) dut (
        .Clk(clk), .Reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .occupancy(occupancy), .busy(busy), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural FPU ----------------
    bit          fpu_hang = 1'b0;
    bit          fpu_fixed_en = 1'b1;
    int          fpu_fixed_lat = 0;
    logic [31:0] fpu_fixed_ret = '0;
    int          fpu_cnt = 0;
    logic        fpu_done_r = 1'b0;

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
        return int'(b[5:0]) + int'(a[0]);
    endfunction

    function automatic logic [31:0] fake_fpu(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // Done rises lat+1 edges after the start pin falls and stays until the next start.
    always @(posedge clk) begin
        if (fpu_start) begin
            fpu_cnt    <= 0;
            fpu_done_r <= 1'b0;
        end else if (!fpu_hang && !fpu_done_r) begin
            if (fpu_cnt >= (fpu_fixed_en ? fpu_fixed_lat : model_lat(fpu_a, fpu_b)))
                fpu_done_r <= 1'b1;
            else
                fpu_cnt <= fpu_cnt + 1;
        end
    end

    assign fpu_done   = fpu_done_r;
    assign fpu_result = fpu_fixed_en ? fpu_fixed_ret : fake_fpu(fpu_op, fpu_a, fpu_b);

    // The sequencer sees Done one edge after it rises and gives up after TIMEOUT WAIT edges.
    function automatic logic [SB_W-1:0] ref_rsp(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [3:0] tag);
        int lat;
        logic [31:0] val;
        lat = fpu_fixed_en ? fpu_fixed_lat : model_lat(a, b);
        val = fpu_fixed_en ? fpu_fixed_ret : fake_fpu(op, a, b);
        if (fpu_hang || (lat + 2 > TIMEOUT)) return {tag, 1'b1, QNAN};
        return {tag, 1'b0, val};
    endfunction

    // ---------------- monitors ----------------
    int              start_len = 0;
    bit              start_prev = 1'b0;
    bit              stall_prev = 1'b0;
    logic [SB_W-1:0] stall_val;

    always @(negedge clk) begin
        logic [SB_W-1:0]  cur;
        logic [ISS_W-1:0] e_iss;
        logic [SB_W-1:0]  e_rsp;
        cur = {rsp_tag, rsp_timeout, rsp_result};
        if (!rst_n) begin
            iss_q.delete();
            exp_q.delete();
            start_len  = 0;
            start_prev = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (fpu_start && !start_prev) begin
                check("issue_pending", iss_q.size() > 0, 1);
                if (iss_q.size() > 0) begin
                    e_iss = iss_q.pop_front();
                    check("issue_operands", {fpu_op, fpu_a, fpu_b}, e_iss);
                end
            end
            if (fpu_start) start_len++;
            else if (start_prev) begin
                check("start_width", start_len, START_CYCLES);
                start_len = 0;
            end
            start_prev = fpu_start;
            if (stall_prev) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", cur, stall_val);
                check("rsp_hold_no_start", fpu_start, 0);
            end
            stall_prev = rsp_valid && !rsp_ready;
            stall_val  = cur;
            if (sb_en && rsp_valid && rsp_ready) begin
                check("rsp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_rsp = exp_q.pop_front();
                    check("rsp_scoreboard", cur, e_rsp);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        check("cmd_accept", ok, 1);
        if (ok) begin
            iss_q.push_back({op, a, b});
            if (sb_en) exp_q.push_back(ref_rsp(op, a, b, tag));
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc, output logic [SB_W-1:0] got);
        cyc = -1;
        got = '0;
        rsp_ready = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = t;
                got = {rsp_tag, rsp_timeout, rsp_result};
                break;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        bit          hang;
        int          lat;
        logic [31:0] ret;
        logic [31:0] exp_res;
        bit          exp_to;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int i);
        int cyc;
        logic [SB_W-1:0] got;
        fpu_fixed_en  = 1'b1;
        fpu_hang      = vecs[i].hang;
        fpu_fixed_lat = vecs[i].lat;
        fpu_fixed_ret = vecs[i].ret;
        push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
        wait_rsp(cyc, got);
        check($sformatf("vec%0d_rsp", i), got, {vecs[i].tag, vecs[i].exp_to, vecs[i].exp_res});
        check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
    endtask

    initial begin
        int acc;
        int cyc;
        logic [SB_W-1:0] got;

        // cycles = accept edge to first negedge showing rsp_valid
        vecs[0] = '{2'b00, 32'h404CCCCD, 32'h3F800000, 4'd3, 1'b0, 9,  32'h40866666, 32'h40866666, 1'b0, 15};
        vecs[1] = '{2'b10, 32'h00000011, 32'h00000022, 4'd7, 1'b0, 62, 32'h12345678, 32'h12345678, 1'b0, 68};
        vecs[2] = '{2'b01, 32'h00000033, 32'h00000044, 4'd9, 1'b0, 63, 32'h87654321, QNAN,         1'b1, 68};
        vecs[3] = '{2'b11, 32'hDEADBEEF, 32'h01020304, 4'd12, 1'b1, 0, 32'h11111111, QNAN,         1'b1, 68};
        vecs[4] = '{2'b00, 32'h3F800000, 32'h3F800000, 4'd15, 1'b0, 0, 32'h40000000, 32'h40000000, 1'b0, 6};
        vecs[5] = '{2'b01, 32'h40400000, 32'h3F800000, 4'd0, 1'b0, 4,  32'h40000000, 32'h40000000, 1'b0, 10};

        // reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_fpu_start", fpu_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_fpu_a", fpu_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // table vectors: add, done on expiry edge, one past, hang, back-to-back recovery
        for (int i = 0; i < 6; i++) run_vec(i);

        // queue full with a stalled FPU, then reset mid-WAIT
        fpu_hang = 1'b1;
        fpu_fixed_en = 1'b1;
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'(i); cmd_a = $urandom; cmd_b = $urandom; cmd_tag = 4'(i + 8);
            @(negedge clk);
            if (cmd_ready) begin
                acc++;
                iss_q.push_back({cmd_op, cmd_a, cmd_b});
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("full_accepted", acc, DEPTH + 1);
        @(negedge clk);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_occupancy", occupancy, DEPTH);
        check("full_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("full_in_wait", dbg_state, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fpu_start", fpu_start, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_cmd_ready", cmd_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_fpu_a", fpu_a, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0);

        // response backpressure with a second command queued behind
        fpu_hang = 1'b0;
        fpu_fixed_lat = 3;
        fpu_fixed_ret = 32'hAAAA5555;
        rsp_ready = 1'b0;
        push(2'b10, 32'h1, 32'h2, 4'd5);
        push(2'b11, 32'h3, 32'h4, 4'd6);
        acc = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rsp_valid) begin acc = 1; break; end
        end
        check("bp_rsp_seen", acc, 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_tag, rsp_timeout, rsp_result, fpu_start},
                  {1'b1, 4'd5, 1'b0, 32'hAAAA5555, 1'b0});
        end
        check("bp_occupancy", occupancy, 1);
        @(posedge clk); #1;
        wait_rsp(cyc, got);
        check("bp_first", got, {4'd5, 1'b0, 32'hAAAA5555});
        wait_rsp(cyc, got);
        check("bp_second", got, {4'd6, 1'b0, 32'hAAAA5555});

        // order: mul, div, sub, add with tags 0..3 through the scoreboard
        fpu_fixed_en = 1'b0;
        sb_en = 1'b1;
        rsp_ready = 1'b1;
        push(2'b10, 32'h00000102, 32'h00000005, 4'd0);
        push(2'b11, 32'h00000304, 32'h00000003, 4'd1);
        push(2'b01, 32'h00000506, 32'h00000007, 4'd2);
        push(2'b00, 32'h00000708, 32'h00000001, 4'd3);
        for (int t = 0; t < 1000 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        check("order_drained", exp_q.size(), 0);
        @(posedge clk); #1;

        // randomized traffic with random response backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b[5:0] = 6'd63;
            else b[5:0] = 6'($urandom_range(0, 20));
            push(2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        for (int t = 0; t < 5000 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        check("rand_drained", exp_q.size(), 0);
        check("rand_idle", busy, 0);
        rand_ready = 1'b0;
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
